useq_ctl: RTL

- Microprogram sequencer controller: computes the next control-store address each cycle from a 3-bit sequencer opcode, a selectable condition, branch/map addresses, a return-address stack and a loop counter.
- Sits between the control-store word fields and the control-store address port.
- Extends the basic PC/stack/mux path with conditional branching, counted loops, stack-fault detection and halt.

---
 rtl/useq_ctl_if.sv | 30 +++
 rtl/useq_ctl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/useq_ctl_if.sv
// Sequencer control-word fields in, control-store address and stack status out.
interface useq_ctl_if #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic          en;
    logic [2:0]    opc;
    logic [3:0]    cc;
    logic [1:0]    csel;
    logic          pol;
    logic [AW-1:0] dirb;
    logic [AW-1:0] diri;
    logic [AW-1:0] pc;
    logic [SPW-1:0] sp;
    logic          stk_full;
    logic          stk_err;
    logic          halted;

    modport master (
        output en, opc, cc, csel, pol, dirb, diri,
        input  pc, sp, stk_full, stk_err, halted
    );

    modport slave (
        input  en, opc, cc, csel, pol, dirb, diri,
        output pc, sp, stk_full, stk_err, halted
    );
endinterface

// File: rtl/useq_ctl.sv
// Microprogram sequencer: next-address select with return stack,
// loop counter, conditional branch, sticky stack-fault flag and halt.
module useq_ctl #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic        ck,
    input  logic        rst,
    useq_ctl_if.slave   bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [2:0] {
        OP_CONT = 3'd0,
        OP_JMAP = 3'd1,
        OP_CJP  = 3'd2,
        OP_CJS  = 3'd3,
        OP_CRTN = 3'd4,
        OP_LDCT = 3'd5,
        OP_RPCT = 3'd6,
        OP_HALT = 3'd7
    } op_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } st_e;

    st_e            st_q, st_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [AW-1:0]  stk_q [DEPTH];

    op_e            op;
    logic           cond;
    logic           full;
    logic           empty;
    logic           adv;
    logic           push;
    logic [AW-1:0]  nxt;
    logic [AW-1:0]  top;

    assign op    = op_e'(bus.opc);
    assign cond  = bus.cc[bus.csel] ^ bus.pol;
    assign full  = (sp_q == SP_FULL);
    assign empty = (sp_q == '0);
    assign adv   = bus.en && (st_q == S_RUN);
    assign nxt   = pc_q + 1'b1;
    assign top   = stk_q[IW'(sp_q - 1'b1)];

    always_comb begin
        st_d  = st_q;
        pc_d  = pc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (adv) begin
            pc_d = nxt;
            unique case (op)
                OP_CONT: ;
                OP_JMAP: pc_d = bus.diri;
                OP_CJP: begin
                    if (cond) pc_d = bus.dirb;
                end
                OP_CJS: begin
                    if (cond && !full) begin
                        push = 1'b1;
                        sp_d = sp_q + 1'b1;
                        pc_d = bus.dirb;
                    end else if (cond) begin
                        err_d = 1'b1;
                    end
                end
                OP_CRTN: begin
                    if (cond && !empty) begin
                        sp_d = sp_q - 1'b1;
                        pc_d = top;
                    end else if (cond) begin
                        err_d = 1'b1;
                    end
                end
                OP_LDCT: cnt_d = bus.dirb;
                OP_RPCT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        pc_d  = bus.dirb;
                    end
                end
                OP_HALT: begin
                    pc_d = pc_q;
                    st_d = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            st_q  <= S_RUN;
            pc_q  <= '0;
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch.
    always_ff @(posedge ck) begin
        if (push) stk_q[IW'(sp_q)] <= nxt;
    end

    assign bus.pc       = pc_q;
    assign bus.sp       = sp_q;
    assign bus.stk_full = full;
    assign bus.stk_err  = err_q;
    assign bus.halted   = (st_q == S_HALT);
endmodule
